// File: rtl/sram189_pkg.sv
// ----------------------------------------------------------------------------
// sram189_pkg : shared widths, FSM state type and helpers for sram189_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sram189_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram189_phase_timer.sv
// ----------------------------------------------------------------------------
// sram189_phase_timer : loadable down-counter flagging the last cycle of a phase
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram189_phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             last
);

  logic [WIDTH-1:0] r_cnt;

  // Loaded with (cycles - 1), so a count of zero marks the final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign last = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/sram189_ctrl.sv
// ----------------------------------------------------------------------------
// sram189_ctrl : host-side access sequencer and clear sweep for a 74F189 SRAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram189_ctrl
  import sram189_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clr_start,
  output logic              clr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_cs_n,
  output logic              mem_we_n,
  input  logic [DATA_W-1:0] mem_o
);

  localparam int TW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

  state_t          r_state;
  logic            r_we;
  logic            r_clr;
  logic            w_last;
  logic            w_load;
  logic [TW-1:0]   w_load_val;

  // The timer is reloaded on every phase change with the length of the phase
  // being entered; IDLE keeps it primed for SETUP.
  assign w_load = (r_state == IDLE) || w_last;

  always_comb begin
    w_load_val = TW'(SETUP_CYC - 1);
    case (r_state)
      SETUP:   w_load_val = TW'(PULSE_CYC - 1);
      ACCESS:  w_load_val = TW'(HOLD_CYC - 1);
      default: w_load_val = TW'(SETUP_CYC - 1);
    endcase
  end

  sram189_phase_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .last     (w_last)
  );

  // A same-cycle clear request pre-empts the host.
  assign req_ready = (r_state == IDLE) && !clr_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_clr     <= 1'b0;
      mem_a     <= '0;
      mem_d     <= '0;
      mem_cs_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      clr_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      clr_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clr_start) begin
            r_clr    <= 1'b1;
            r_we     <= 1'b1;
            mem_a    <= '0;
            mem_d    <= '0;
            mem_cs_n <= 1'b0;
            busy     <= 1'b1;
            r_state  <= SETUP;
          end else if (req_valid) begin
            r_clr    <= 1'b0;
            r_we     <= req_we;
            mem_a    <= req_addr;
            mem_d    <= req_wdata;
            mem_cs_n <= 1'b0;
            busy     <= 1'b1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          if (w_last) begin
            mem_we_n <= !r_we;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_last) begin
            mem_we_n <= 1'b1;
            r_state  <= HOLD;
            if (!r_we) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= ~mem_o;
            end
          end
        end
        HOLD: begin
          if (w_last) begin
            if (r_clr && (mem_a != ADDR_W'(DEPTH - 1))) begin
              mem_a   <= mem_a + ADDR_W'(1);
              r_state <= SETUP;
            end else begin
              mem_cs_n <= 1'b1;
              busy     <= 1'b0;
              clr_done <= r_clr;
              r_clr    <= 1'b0;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram189_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram189_ctrl : two controller lanes (default and 2/3/2 timing), each on a
// 74F189 model, checked against a cycle-level reference and directed vectors
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sram189_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_we    [2];
  logic [3:0] req_addr  [2];
  logic [3:0] req_wdata [2];
  logic       rsp_valid [2];
  logic [3:0] rsp_rdata [2];
  logic       clr_start [2];
  logic       clr_done  [2];
  logic       busy      [2];
  logic [3:0] mem_a     [2];
  logic [3:0] mem_d     [2];
  logic       mem_cs_n  [2];
  logic       mem_we_n  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [3:0] sram [16];
    wire  [3:0] w_mo = (!mem_cs_n[g] && mem_we_n[g]) ? ~sram[mem_a[g]] : 4'h0;

    always @(negedge clk)
      if (!mem_cs_n[g] && !mem_we_n[g]) sram[mem_a[g]] <= mem_d[g];

    sram189_ctrl #(
      .SETUP_CYC(g ? 2 : 1),
      .PULSE_CYC(g ? 3 : 2),
      .HOLD_CYC (g ? 2 : 1)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .clr_start (clr_start[g]),
      .clr_done  (clr_done[g]),
      .busy      (busy[g]),
      .mem_a     (mem_a[g]),
      .mem_d     (mem_d[g]),
      .mem_cs_n  (mem_cs_n[g]),
      .mem_we_n  (mem_we_n[g]),
      .mem_o     (w_mo)
    );
  end

  function automatic int sc(int l); return l ? 2 : 1; endfunction
  function automatic int pc(int l); return l ? 3 : 2; endfunction
  function automatic int hc(int l); return l ? 2 : 1; endfunction

  task automatic chk(string nm, int act, int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: position mk (1..S+P+H) within the current word, 0 when idle.
  int         mk    [2];
  logic       mwe   [2];
  logic       mclr  [2];
  logic [3:0] maddr [2];
  logic [3:0] mdata [2];
  logic       xrv   [2];
  logic [3:0] xrd   [2];
  logic       xdone [2];
  logic [3:0] refm  [2][16];

  always @(posedge clk or negedge rst_n) begin
    for (int l = 0; l < 2; l++) begin
      if (!rst_n) begin
        mk[l] = 0; mwe[l] = 1'b0; mclr[l] = 1'b0; maddr[l] = 4'h0; mdata[l] = 4'h0;
        xrv[l] = 1'b0; xrd[l] = 4'h0; xdone[l] = 1'b0;
      end else begin
        xrv[l] = 1'b0;
        xdone[l] = 1'b0;
        if (mk[l] == 0) begin
          if (clr_start[l]) begin
            mclr[l] = 1'b1; mwe[l] = 1'b1; maddr[l] = 4'h0; mdata[l] = 4'h0; mk[l] = 1;
            refm[l][0] = 4'h0;
          end else if (req_valid[l]) begin
            mclr[l] = 1'b0; mwe[l] = req_we[l]; maddr[l] = req_addr[l];
            mdata[l] = req_wdata[l]; mk[l] = 1;
            if (req_we[l]) refm[l][req_addr[l]] = req_wdata[l];
          end
        end else if (mk[l] == sc(l) + pc(l) + hc(l)) begin
          if (mclr[l] && maddr[l] != 4'hF) begin
            maddr[l] = maddr[l] + 4'h1;
            mk[l] = 1;
            refm[l][maddr[l]] = 4'h0;
          end else begin
            mk[l] = 0;
            xdone[l] = mclr[l];
            mclr[l] = 1'b0;
          end
        end else begin
          mk[l] = mk[l] + 1;
        end
        if (!mwe[l] && mk[l] == sc(l) + pc(l) + 1) begin
          xrv[l] = 1'b1;
          xrd[l] = refm[l][maddr[l]];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d mem_cs_n", l), int'(mem_cs_n[l]), int'(mk[l] == 0));
      chk($sformatf("L%0d mem_we_n", l), int'(mem_we_n[l]),
          int'(!(mwe[l] && mk[l] > sc(l) && mk[l] <= sc(l) + pc(l))));
      chk($sformatf("L%0d busy", l), int'(busy[l]), int'(mk[l] != 0));
      chk($sformatf("L%0d req_ready", l), int'(req_ready[l]), int'(mk[l] == 0 && !clr_start[l]));
      chk($sformatf("L%0d mem_a", l), int'(mem_a[l]), int'(maddr[l]));
      chk($sformatf("L%0d mem_d", l), int'(mem_d[l]), int'(mdata[l]));
      chk($sformatf("L%0d rsp_valid", l), int'(rsp_valid[l]), int'(xrv[l]));
      chk($sformatf("L%0d rsp_rdata", l), int'(rsp_rdata[l]), int'(xrd[l]));
      chk($sformatf("L%0d clr_done", l), int'(clr_done[l]), int'(xdone[l]));
    end
  end

  int         q1c [$];
  logic [3:0] q1d [$];
  always @(negedge clk)
    if (rsp_valid[1]) begin
      q1c.push_back(cyc);
      q1d.push_back(rsp_rdata[1]);
    end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(int l, bit we, logic [3:0] a, logic [3:0] d, bit keep, output int acc);
    req_we[l] = we; req_addr[l] = a; req_wdata[l] = d; req_valid[l] = 1'b1;
    acc = -1;
    for (int i = 0; i < 200 && acc < 0; i++) begin
      @(negedge clk);
      if (req_ready[l]) begin
        @(posedge clk); #2;
        acc = cyc;
      end
    end
    if (acc < 0) begin
      chk("accept_timeout", 0, 1);
      @(posedge clk); #2;
    end
    if (!keep) req_valid[l] = 1'b0;
  endtask

  task automatic get_rsp(int l, int acc, output int lat, output logic [3:0] d);
    lat = -1; d = 4'h0;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (rsp_valid[l]) begin lat = cyc - acc; d = rsp_rdata[l]; end
    end
    @(posedge clk); #2;
  endtask

  initial begin
    int         acc, acc0, acc1, acc2, lat, c0, done_cyc, cs_cnt, rsp_seen, nz;
    bit         a_ok;
    logic [5:0] we_mask;
    logic [3:0] d;
    logic [3:0] exp_d [3];

    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    for (int l = 0; l < 2; l++) begin
      req_valid[l] = 1'b0; req_we[l] = 1'b0; req_addr[l] = 4'h0;
      req_wdata[l] = 4'h0; clr_start[l] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset cs_n", int'(mem_cs_n[0]), 1);
    chk("reset ready", int'(req_ready[0]), 1);
    chk("reset busy", int'(busy[0]), 0);
    chk("reset mem_a", int'(mem_a[0]), 0);
    @(posedge clk); #2;

    // Write 3 <- A: pin waveform over the five cycles after accept.
    issue(0, 1'b1, 4'h3, 4'hA, 1'b0, acc);
    we_mask = '0; cs_cnt = 0; rsp_seen = 0; a_ok = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (!mem_cs_n[0]) cs_cnt++;
      if (!mem_we_n[0]) we_mask[k] = 1'b1;
      if (rsp_valid[0]) rsp_seen++;
      if (k <= 4 && (mem_a[0] != 4'h3 || mem_d[0] != 4'hA)) a_ok = 1'b0;
    end
    chk("wr cs_low_cycles", cs_cnt, 4);
    chk("wr we_low_mask", int'(we_mask), 6'b001100);
    chk("wr no_rsp", rsp_seen, 0);
    chk("wr addr_data_stable", int'(a_ok), 1);
    @(posedge clk); #2;

    issue(0, 1'b0, 4'h3, 4'h0, 1'b0, acc);
    get_rsp(0, acc, lat, d);
    chk("rd3 latency", lat, 3);
    chk("rd3 data", int'(d), 4'hA);

    for (int a = 0; a < 16; a++) issue(0, 1'b1, 4'(a), 4'hF, 1'b0, acc);
    issue(0, 1'b0, 4'hC, 4'h0, 1'b0, acc);
    get_rsp(0, acc, lat, d);
    chk("rdC before clear", int'(d), 4'hF);

    // Clear and a read of 7 raised together: the sweep wins.
    clr_start[0] = 1'b1;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 4'h7;
    @(negedge clk);
    chk("ready low with clr_start", int'(req_ready[0]), 0);
    @(posedge clk); #2;
    clr_start[0] = 1'b0;
    c0 = cyc;
    done_cyc = -1;
    for (int i = 0; i < 100 && done_cyc < 0; i++) begin
      @(negedge clk);
      if (clr_done[0]) begin
        done_cyc = cyc;
        chk("ready in clr_done cycle", int'(req_ready[0]), 1);
      end
    end
    chk("sweep length", done_cyc - c0, 64);
    @(posedge clk); #2;
    acc = cyc;
    req_valid[0] = 1'b0;
    get_rsp(0, acc, lat, d);
    chk("held rd7 latency", lat, 3);
    chk("held rd7 data", int'(d), 0);
    nz = 0;
    for (int a = 0; a < 16; a++) if (g_lane[0].sram[a] != 4'h0) nz++;
    chk("sram words nonzero after clear", nz, 0);
    issue(0, 1'b0, 4'hF, 4'h0, 1'b0, acc);
    get_rsp(0, acc, lat, d);
    chk("rdF after clear", int'(d), 0);

    // Reset in the middle of a write pulse.
    issue(0, 1'b1, 4'h5, 4'h9, 1'b0, acc);
    @(posedge clk); #3;
    chk("we_n low in access", int'(mem_we_n[0]), 0);
    rst_n = 1'b0;
    #1;
    chk("async rst we_n", int'(mem_we_n[0]), 1);
    chk("async rst cs_n", int'(mem_cs_n[0]), 1);
    chk("async rst busy", int'(busy[0]), 0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after rst", int'(req_ready[0]), 1);
    chk("no rsp after rst", int'(rsp_valid[0]), 0);
    @(posedge clk); #2;

    // Lane 1 (2/3/2): back-to-back reads.
    issue(1, 1'b1, 4'h2, 4'h6, 1'b0, acc);
    issue(1, 1'b1, 4'h9, 4'hC, 1'b0, acc);
    q1c.delete(); q1d.delete();
    issue(1, 1'b0, 4'h2, 4'h0, 1'b1, acc0);
    issue(1, 1'b0, 4'h9, 4'h0, 1'b1, acc1);
    issue(1, 1'b0, 4'h2, 4'h0, 1'b0, acc2);
    repeat (12) @(posedge clk); #2;
    chk("b2b spacing 1", acc1 - acc0, 8);
    chk("b2b spacing 2", acc2 - acc1, 8);
    chk("b2b rsp count", q1c.size(), 3);
    exp_d[0] = 4'h6; exp_d[1] = 4'hC; exp_d[2] = 4'h6;
    if (q1c.size() == 3) begin
      chk("b2b lat 0", q1c[0] - acc0, 5);
      chk("b2b lat 1", q1c[1] - acc1, 5);
      chk("b2b lat 2", q1c[2] - acc2, 5);
      for (int i = 0; i < 3; i++) chk($sformatf("b2b data %0d", i), int'(q1d[i]), int'(exp_d[i]));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
